// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared encodings and types for the two-master AHB-Lite arbiter
//
// Purpose: HTRANS encodings, data-phase owner enum and the packed
//          address-phase control bundle shared by the arbiter and its
//          per-master pending buffer.
// Ports:   none (package).
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  // Every address-phase control except the address itself, which depends on AW.
  typedef struct packed {
    logic [1:0] htrans;
    logic       hwrite;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic [3:0] hprot;
    logic       hmastlock;
  } ahb_ctrl_t;

  // NONSEQ and SEQ carry a transfer; IDLE and BUSY never do.
  function automatic logic trans_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_req_buf.sv
// rtl/ahb_req_buf.sv - one-entry pending address-phase buffer for one master
//
// Purpose: holds an address phase that the master considers accepted but
//          that lost arbitration (or met a stalled slave) in its cycle.
// Ports:   core_clk, reset_l      clock, async active-low reset
//          i_cap                  capture i_haddr/i_ctrl, entry becomes valid
//          i_clr                  entry was issued to the slave, drop it
//          i_haddr, i_ctrl        live address phase from the master
//          o_valid, o_haddr, o_ctrl  stored entry
module ahb_req_buf
  import ahb_arb_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          core_clk,
  input  logic          reset_l,
  input  logic          i_cap,
  input  logic          i_clr,
  input  logic [AW-1:0] i_haddr,
  input  ahb_ctrl_t     i_ctrl,
  output logic          o_valid,
  output logic [AW-1:0] o_haddr,
  output ahb_ctrl_t     o_ctrl
);

  logic          r_valid;
  logic [AW-1:0] r_haddr;
  ahb_ctrl_t     r_ctrl;

  // Capture and clear never coincide: a master with a valid entry sees
  // hready=0 and so cannot present a new live address phase.
  always_ff @(posedge core_clk or negedge reset_l) begin
    if (!reset_l) begin
      r_valid <= 1'b0;
      r_haddr <= '0;
      r_ctrl  <= '0;
    end else if (i_cap) begin
      r_valid <= 1'b1;
      r_haddr <= i_haddr;
      r_ctrl  <= i_ctrl;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_haddr = r_haddr;
  assign o_ctrl  = r_ctrl;

endmodule

// File: rtl/ahb_lite_arb2.sv
// rtl/ahb_lite_arb2.sv - two-master (LSU m0, IFU m1) AHB-Lite arbiter onto one slave
//
// Purpose: round-robin arbitration of each slave address slot, zero-latency
//          pass-through for an uncontested master, one pending buffer per
//          master, data-phase owner tracking for hwdata/hready/hresp routing.
// Ports:   core_clk, reset_l         clock, async active-low reset
//          mX_haddr..mX_hmastlock    master X address phase (X = 0, 1)
//          mX_hwdata                 master X write data
//          mX_hrdata/hready/hresp    response to master X
//          s_haddr..s_hwdata         address phase and write data to slave
//          s_hrdata/hready/hresp     slave response (HREADYOUT on s_hready)
module ahb_lite_arb2
  import ahb_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic          core_clk,
  input  logic          reset_l,
  input  logic [AW-1:0] m0_haddr,
  input  logic [1:0]    m0_htrans,
  input  logic          m0_hwrite,
  input  logic [2:0]    m0_hsize,
  input  logic [2:0]    m0_hburst,
  input  logic [3:0]    m0_hprot,
  input  logic          m0_hmastlock,
  input  logic [DW-1:0] m0_hwdata,
  output logic [DW-1:0] m0_hrdata,
  output logic          m0_hready,
  output logic          m0_hresp,
  input  logic [AW-1:0] m1_haddr,
  input  logic [1:0]    m1_htrans,
  input  logic          m1_hwrite,
  input  logic [2:0]    m1_hsize,
  input  logic [2:0]    m1_hburst,
  input  logic [3:0]    m1_hprot,
  input  logic          m1_hmastlock,
  input  logic [DW-1:0] m1_hwdata,
  output logic [DW-1:0] m1_hrdata,
  output logic          m1_hready,
  output logic          m1_hresp,
  output logic [AW-1:0] s_haddr,
  output logic [1:0]    s_htrans,
  output logic          s_hwrite,
  output logic [2:0]    s_hsize,
  output logic [2:0]    s_hburst,
  output logic [3:0]    s_hprot,
  output logic          s_hmastlock,
  output logic [DW-1:0] s_hwdata,
  input  logic [DW-1:0] s_hrdata,
  input  logic          s_hready,
  input  logic          s_hresp
);

  ahb_ctrl_t     w_m0_ctrl, w_m1_ctrl, w_b0_ctrl, w_b1_ctrl, w_sel_ctrl, r_last_ctrl;
  logic [AW-1:0] w_b0_addr, w_b1_addr, w_sel_addr, r_last_addr;
  logic          w_b0_v, w_b1_v, w_m0_live, w_m1_live, w_req0, w_req1;
  logic          w_issue, w_cap0, w_cap1, w_clr0, w_clr1;
  owner_e        w_gnt, r_dp_owner, r_prev_own;
  logic          r_ptr;   // 0: m0 preferred on contention, 1: m1 preferred

  assign w_m0_ctrl = {m0_htrans, m0_hwrite, m0_hsize, m0_hburst, m0_hprot, m0_hmastlock};
  assign w_m1_ctrl = {m1_htrans, m1_hwrite, m1_hsize, m1_hburst, m1_hprot, m1_hmastlock};

  // Master-side responses are steered by the data-phase owner; a master with
  // a pending entry is stalled so it holds its next address phase.
  always_comb begin
    m0_hready = 1'b1;
    if (r_dp_owner == OWN_M0) m0_hready = s_hready;
    else if (w_b0_v)          m0_hready = 1'b0;
    m1_hready = 1'b1;
    if (r_dp_owner == OWN_M1) m1_hready = s_hready;
    else if (w_b1_v)          m1_hready = 1'b0;
  end

  assign m0_hresp  = (r_dp_owner == OWN_M0) & s_hresp;
  assign m1_hresp  = (r_dp_owner == OWN_M1) & s_hresp;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;

  // A live address phase exists only when the master itself samples hready high.
  assign w_m0_live = trans_active(m0_htrans) & m0_hready;
  assign w_m1_live = trans_active(m1_htrans) & m1_hready;
  assign w_req0    = w_b0_v | w_m0_live;
  assign w_req1    = w_b1_v | w_m1_live;

  // Grant is gated by reset so live masters cannot reach the slave during reset.
  always_comb begin
    w_gnt = OWN_NONE;
    if (reset_l) begin
      if (w_req0 && w_req1) w_gnt = r_ptr ? OWN_M1 : OWN_M0;
      else if (w_req0)      w_gnt = OWN_M0;
      else if (w_req1)      w_gnt = OWN_M1;
    end
  end

  always_comb begin
    w_sel_addr        = r_last_addr;
    w_sel_ctrl        = r_last_ctrl;
    w_sel_ctrl.htrans = HTRANS_IDLE;
    case (w_gnt)
      OWN_M0: begin
        w_sel_addr = w_b0_v ? w_b0_addr : m0_haddr;
        w_sel_ctrl = w_b0_v ? w_b0_ctrl : w_m0_ctrl;
      end
      OWN_M1: begin
        w_sel_addr = w_b1_v ? w_b1_addr : m1_haddr;
        w_sel_ctrl = w_b1_v ? w_b1_ctrl : w_m1_ctrl;
      end
      default: ;
    endcase
    // A burst resumed after another master cut in must restart as NONSEQ.
    if (w_gnt != OWN_NONE && w_gnt != r_prev_own) w_sel_ctrl.htrans = HTRANS_NONSEQ;
  end

  assign w_issue = (w_gnt != OWN_NONE) & s_hready;
  assign w_cap0  = w_m0_live & ~(w_issue & (w_gnt == OWN_M0));
  assign w_cap1  = w_m1_live & ~(w_issue & (w_gnt == OWN_M1));
  assign w_clr0  = w_b0_v & w_issue & (w_gnt == OWN_M0);
  assign w_clr1  = w_b1_v & w_issue & (w_gnt == OWN_M1);

  ahb_req_buf #(.AW(AW)) u_buf0 (
    .core_clk (core_clk), .reset_l (reset_l),
    .i_cap    (w_cap0),   .i_clr   (w_clr0),
    .i_haddr  (m0_haddr), .i_ctrl  (w_m0_ctrl),
    .o_valid  (w_b0_v),   .o_haddr (w_b0_addr), .o_ctrl (w_b0_ctrl)
  );

  ahb_req_buf #(.AW(AW)) u_buf1 (
    .core_clk (core_clk), .reset_l (reset_l),
    .i_cap    (w_cap1),   .i_clr   (w_clr1),
    .i_haddr  (m1_haddr), .i_ctrl  (w_m1_ctrl),
    .o_valid  (w_b1_v),   .o_haddr (w_b1_addr), .o_ctrl (w_b1_ctrl)
  );

  always_ff @(posedge core_clk or negedge reset_l) begin
    if (!reset_l) begin
      r_ptr       <= 1'b0;
      r_dp_owner  <= OWN_NONE;
      r_prev_own  <= OWN_NONE;
      r_last_addr <= '0;
      r_last_ctrl <= '0;
    end else if (s_hready) begin
      r_dp_owner <= w_gnt;
      if (w_gnt != OWN_NONE) begin
        r_prev_own  <= w_gnt;
        r_last_addr <= w_sel_addr;
        r_last_ctrl <= w_sel_ctrl;
        // Locked transfers keep preference on the grantee; otherwise hand it over.
        r_ptr <= w_sel_ctrl.hmastlock ? (w_gnt == OWN_M1) : (w_gnt == OWN_M0);
      end
    end
  end

  assign s_haddr     = w_sel_addr;
  assign s_htrans    = w_sel_ctrl.htrans;
  assign s_hwrite    = w_sel_ctrl.hwrite;
  assign s_hsize     = w_sel_ctrl.hsize;
  assign s_hburst    = w_sel_ctrl.hburst;
  assign s_hprot     = w_sel_ctrl.hprot;
  assign s_hmastlock = w_sel_ctrl.hmastlock;
  assign s_hwdata    = (r_dp_owner == OWN_M0) ? m0_hwdata :
                       (r_dp_owner == OWN_M1) ? m1_hwdata : '0;

endmodule

// File: tb/tb_ahb_lite_arb2.sv
// tb/tb_ahb_lite_arb2.sv - scoreboard bench for the two-master AHB-Lite arbiter
module tb_ahb_lite_arb2;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic        core_clk, reset_l;
  logic [31:0] m0_haddr, m1_haddr, s_haddr;
  logic [1:0]  m0_htrans, m1_htrans, s_htrans;
  logic        m0_hwrite, m1_hwrite, s_hwrite;
  logic [2:0]  m0_hsize, m1_hsize, s_hsize, m0_hburst, m1_hburst, s_hburst;
  logic [3:0]  m0_hprot, m1_hprot, s_hprot;
  logic        m0_hmastlock, m1_hmastlock, s_hmastlock;
  logic [63:0] m0_hwdata, m1_hwdata, s_hwdata, m0_hrdata, m1_hrdata, s_hrdata;
  logic        m0_hready, m1_hready, s_hready, m0_hresp, m1_hresp, s_hresp;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        wr;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ahb_lite_arb2 #(.AW(32), .DW(64)) dut (
    .core_clk (core_clk), .reset_l (reset_l),
    .m0_haddr (m0_haddr), .m0_htrans (m0_htrans), .m0_hwrite (m0_hwrite),
    .m0_hsize (m0_hsize), .m0_hburst (m0_hburst), .m0_hprot (m0_hprot),
    .m0_hmastlock (m0_hmastlock), .m0_hwdata (m0_hwdata),
    .m0_hrdata (m0_hrdata), .m0_hready (m0_hready), .m0_hresp (m0_hresp),
    .m1_haddr (m1_haddr), .m1_htrans (m1_htrans), .m1_hwrite (m1_hwrite),
    .m1_hsize (m1_hsize), .m1_hburst (m1_hburst), .m1_hprot (m1_hprot),
    .m1_hmastlock (m1_hmastlock), .m1_hwdata (m1_hwdata),
    .m1_hrdata (m1_hrdata), .m1_hready (m1_hready), .m1_hresp (m1_hresp),
    .s_haddr (s_haddr), .s_htrans (s_htrans), .s_hwrite (s_hwrite),
    .s_hsize (s_hsize), .s_hburst (s_hburst), .s_hprot (s_hprot),
    .s_hmastlock (s_hmastlock), .s_hwdata (s_hwdata),
    .s_hrdata (s_hrdata), .s_hready (s_hready), .s_hresp (s_hresp)
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  task automatic drv(input int m, input logic [31:0] a, input logic [1:0] t,
                     input logic w, input logic lk);
    if (m == 0) begin
      m0_haddr = a; m0_htrans = t; m0_hwrite = w; m0_hmastlock = lk;
    end else begin
      m1_haddr = a; m1_htrans = t; m1_hwrite = w; m1_hmastlock = lk;
    end
  endtask

  task automatic idle(input int m);
    drv(m, 32'h0, ID, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] a, input logic [1:0] t, input logic w);
    exp_t e;
    e.addr = a; e.trans = t; e.wr = w;
    exp_q.push_back(e);
  endtask

  // Monitor: every address phase the slave accepts must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge core_clk);
      if (reset_l && s_hready && s_htrans[1]) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_issue: got addr %0h trans %0h expected none", s_haddr, s_htrans);
        end else begin
          e = exp_q.pop_front();
          chk("issue_addr", s_haddr, e.addr);
          chk("issue_trans", s_htrans, e.trans);
          chk("issue_write", s_hwrite, e.wr);
        end
      end
    end
  end

  initial begin
    reset_l = 1'b0;
    idle(0); idle(1);
    m0_hsize = 3'd3; m1_hsize = 3'd3; m0_hburst = 3'd0; m1_hburst = 3'd3;
    m0_hprot = 4'h3; m1_hprot = 4'h2; m0_hwdata = '0; m1_hwdata = 64'h2222;
    s_hready = 1'b1; s_hresp = 1'b0; s_hrdata = 64'hCAFE_F00D_1234_5678;
    #2;
    chk("rst_s_htrans", s_htrans, ID);
    chk("rst_s_haddr", s_haddr, 0);
    chk("rst_m0_hready", m0_hready, 1);
    chk("rst_m1_hready", m1_hready, 1);
    chk("rst_m0_hresp", m0_hresp, 0);
    chk("rst_s_hwdata", s_hwdata, 0);
    chk("hrdata_bcast_m0", m0_hrdata, 64'hCAFE_F00D_1234_5678);
    chk("hrdata_bcast_m1", m1_hrdata, 64'hCAFE_F00D_1234_5678);
    repeat (2) @(posedge core_clk);
    #1 reset_l = 1'b1;

    // Uncontested m1 read passes straight through.
    step(); drv(1, 32'h8000_0000, NS, 1'b0, 1'b0); push(32'h8000_0000, NS, 1'b0); #1;
    chk("solo_s_haddr", s_haddr, 32'h8000_0000);
    chk("solo_s_htrans", s_htrans, NS);
    chk("solo_m0_hready", m0_hready, 1);
    step(); idle(1); s_hready = 1'b0; #1;
    chk("m1_dp_hready_low", m1_hready, 0);
    chk("m0_free_hready", m0_hready, 1);
    chk("idle_htrans", s_htrans, ID);
    chk("idle_hold_addr", s_haddr, 32'h8000_0000);
    step(); s_hready = 1'b1; #1;
    chk("m1_dp_hready_high", m1_hready, 1);

    // Simultaneous requests with m0 preferred.
    step(); drv(0, 32'h1000, NS, 1'b1, 1'b0); drv(1, 32'h2000, NS, 1'b0, 1'b0);
    push(32'h1000, NS, 1'b1); push(32'h2000, NS, 1'b0);
    step(); idle(0); idle(1); m0_hwdata = 64'h1111; #1;
    chk("m1_buffered_hready", m1_hready, 0);
    chk("wdata_from_m0", s_hwdata, 64'h1111);
    step(); #1;
    chk("m1_owner_hready", m1_hready, 1);
    chk("wdata_from_m1", s_hwdata, 64'h2222);

    // m1 INCR4 burst interrupted by an m0 write.
    step(); drv(1, 32'h3000, NS, 1'b0, 1'b0); push(32'h3000, NS, 1'b0);
    step(); drv(1, 32'h3008, SQ, 1'b0, 1'b0); drv(0, 32'hD058_0000, NS, 1'b1, 1'b0);
    push(32'hD058_0000, NS, 1'b1); push(32'h3008, NS, 1'b0);
    step(); idle(0); m0_hwdata = 64'h41; drv(1, 32'h3010, SQ, 1'b0, 1'b0); #1;
    chk("burst_m1_stalled", m1_hready, 0);
    chk("burst_wdata_41", s_hwdata, 64'h41);
    chk("burst_resume_nonseq", s_htrans, NS);
    step(); push(32'h3010, SQ, 1'b0); #1;
    chk("burst_seq_pass", s_htrans, SQ);
    step(); drv(1, 32'h3018, SQ, 1'b0, 1'b0); push(32'h3018, SQ, 1'b0);
    step(); idle(1); #1;
    chk("idle_hold_addr2", s_haddr, 32'h3018);

    // m0 locked sequence holds off m1.
    step(); drv(0, 32'h4000, NS, 1'b0, 1'b1); drv(1, 32'h5000, NS, 1'b0, 1'b0);
    push(32'h4000, NS, 1'b0);
    step(); drv(0, 32'h4100, NS, 1'b0, 1'b1); idle(1); push(32'h4100, NS, 1'b0); #1;
    chk("lock_m1_wait1", m1_hready, 0);
    step(); drv(0, 32'h4200, NS, 1'b0, 1'b1); push(32'h4200, NS, 1'b0); #1;
    chk("lock_m1_wait2", m1_hready, 0);
    chk("lock_passthru", s_hmastlock, 1);
    step(); idle(0); push(32'h5000, NS, 1'b0); #1;
    chk("lock_release_addr", s_haddr, 32'h5000);
    chk("lock_release_mastlock", s_hmastlock, 0);

    // Two-cycle ERROR on m0's data phase with m1 pending.
    step(); drv(0, 32'h6000, NS, 1'b1, 1'b0); drv(1, 32'h7000, NS, 1'b0, 1'b0);
    push(32'h6000, NS, 1'b1); push(32'h7000, NS, 1'b0);
    step(); idle(0); idle(1); s_hready = 1'b0; s_hresp = 1'b1; #1;
    chk("err1_m0_hresp", m0_hresp, 1);
    chk("err1_m1_hresp", m1_hresp, 0);
    chk("err1_m0_hready", m0_hready, 0);
    chk("err1_m1_hready", m1_hready, 0);
    step(); s_hready = 1'b1; #1;
    chk("err2_m0_hresp", m0_hresp, 1);
    chk("err2_m1_hresp", m1_hresp, 0);
    chk("err2_m0_hready", m0_hready, 1);
    chk("err2_m1_issued", s_haddr, 32'h7000);
    step(); s_hresp = 1'b0; #1;
    chk("post_err_m1_hresp", m1_hresp, 0);

    // Reset lands while m1 is pending and m0 owns a stalled data phase.
    step(); drv(0, 32'h9000, NS, 1'b1, 1'b0); drv(1, 32'hA000, NS, 1'b0, 1'b0);
    push(32'h9000, NS, 1'b1);
    step(); idle(0); m0_hwdata = 64'h55; s_hready = 1'b0; s_hresp = 1'b1; #1;
    chk("pre_rst_m1_pending", m1_hready, 0);
    reset_l = 1'b0; #1;
    chk("mid_rst_s_htrans", s_htrans, ID);
    chk("mid_rst_s_haddr", s_haddr, 0);
    chk("mid_rst_m0_hready", m0_hready, 1);
    chk("mid_rst_m1_hready", m1_hready, 1);
    chk("mid_rst_m0_hresp", m0_hresp, 0);
    chk("mid_rst_s_hwdata", s_hwdata, 0);
    step(); step();
    idle(0); idle(1); s_hready = 1'b1; s_hresp = 1'b0; reset_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      chk("post_rst_no_replay", s_htrans, ID);
      chk("post_rst_m1_hready", m1_hready, 1);
    end
    step();
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_arb2.md
AHB_LITE_ARB2 -- requirements
Module: ahb_lite_arb2

Interface
REQ-001 SHALL have parameter AW, default 32, address width.
REQ-002 SHALL have parameter DW, default 64, data width.
REQ-003 SHALL have port core_clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_l  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports m0_haddr/m0_htrans/m0_hwrite/m0_hsize/m0_hburst/m0_hprot/m0_hmastlock  input  AW/2/1/3/3/4/1  master 0 (LSU) address phase.
REQ-006 SHALL have port m0_hwdata  input  DW  master 0 write data.
REQ-007 SHALL have ports m0_hrdata/m0_hready/m0_hresp  output  DW/1/1  master 0 response.
REQ-008 SHALL have ports m1_* identical to m0_* (REQ-005..007)  master 1 (IFU).
REQ-009 SHALL have ports s_haddr/s_htrans/s_hwrite/s_hsize/s_hburst/s_hprot/s_hmastlock/s_hwdata  output  AW/2/1/3/3/4/1/DW  to shared slave.
REQ-010 SHALL have ports s_hrdata/s_hready/s_hresp  input  DW/1/1  slave HRDATA/HREADYOUT/HRESP.

Function
REQ-011 SHALL treat an address phase as valid only when htrans[1]=1 (NONSEQ/SEQ); IDLE/BUSY SHALL never be granted or buffered.
REQ-012 SHALL hold a one-entry pending buffer per master capturing all address-phase controls when that master's valid address phase is sampled with mX_hready=1 but not issued to the slave that cycle.
REQ-013 SHALL arbitrate each slave address slot among live and buffered requests, buffered winning over live for the same master, round-robin between masters; pointer moves to the other master after every issued transfer.
REQ-014 SHALL, when only one master requests and the slave is ready, drive its live controls combinationally to s_* (zero added latency).
REQ-015 SHALL issue a buffered request no earlier than the cycle after capture.
REQ-016 SHALL drive s_htrans=IDLE (2'b00) and hold other s_* at the last issued values when no request is granted.
REQ-017 SHALL force s_htrans=NONSEQ when the granted master differs from the owner of the previous issued address phase; SEQ is otherwise passed through.
REQ-018 SHALL freeze the round-robin pointer on the granted master while its hmastlock=1 and pass that hmastlock to s_hmastlock.
REQ-019 SHALL register data-phase owner dp_owner (NONE/M0/M1), updated to the grantee when s_hready=1 at the address phase, and to NONE when s_hready=1 with no grant.
REQ-020 SHALL mux s_hwdata from dp_owner's master; zero when dp_owner=NONE.
REQ-021 SHALL broadcast s_hrdata to both mX_hrdata.
REQ-022 SHALL drive mX_hready = s_hready while X is dp_owner; 0 while X has a buffered request; 1 otherwise.
REQ-023 SHALL forward s_hresp only to dp_owner; non-owner hresp=0; buffered request retained across an ERROR response.
REQ-024 SHALL bound wait: a buffered request is issued within two slave address slots of capture.

Reset
REQ-025 SHALL on reset_l=0, asynchronously: clear both buffers, dp_owner=NONE, pointer=M0, s_htrans=IDLE, other s_*=0, mX_hready=1, mX_hresp=0.
REQ-026 SHALL discard any in-flight transfer when reset asserts mid-operation; no replay after release.

Structure
REQ-027 SHALL place htrans encodings, owner enum and address-phase control struct in package ahb_arb_pkg.
REQ-028 SHALL implement the pending buffer as sub-module ahb_req_buf, instantiated once per master.

Verification
REQ-029 Only m1 NONSEQ read 0x8000_0000, slave ready -> s_haddr=0x8000_0000 same cycle, m1_hready follows s_hready, m0_hready=1.
REQ-030 Both NONSEQ same cycle, pointer=M0 -> m0 issued, m1 buffered (m1_hready=0), m1 issued next slot with s_htrans=NONSEQ.
REQ-031 m1 4-beat INCR4 SEQ burst interrupted by m0 write 0xD058_0000 data 0x41 -> m0 issued between beats, resumed m1 beat sent as NONSEQ, slave sees 0x41 on s_hwdata.
REQ-032 m0 hmastlock=1 for 3 transfers, m1 requesting -> m1 waits until lock drops, then issued next slot.
REQ-033 Slave ERROR on m0 data phase -> m0_hresp=1 two cycles, m1_hresp=0, m1 buffered request still issued.
REQ-034 reset_l low while m1 buffered and m0 in data phase -> all outputs at REQ-025 values immediately; no transfer issued after release.
